tff_mod_counter: RTL and testbench

//  Synchronous modulo-N up/down counter built from T flip-flop cells; the T-input generator

---
 rtl/tff_cnt_pkg.sv | 26 ++
 rtl/tff_cell.sv | 24 ++
 rtl/tff_mod_counter.sv | 66 ++++++
 tb/tb_tff_mod_counter.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/tff_cnt_pkg.sv
// Shared types and next-state helper for the T-flip-flop modulo counter.
package tff_cnt_pkg;

  typedef enum logic {DIR_DOWN = 1'b0, DIR_UP = 1'b1} dir_e;

  // Widest count the helper supports; arithmetic runs one bit wider.
  localparam int unsigned CNT_W_MAX = 31;

  // Wrapped next value; any out-of-range cur lands on 0 (up) or modulus-1 (down).
  function automatic logic [CNT_W_MAX-1:0] next_count(
    input logic [CNT_W_MAX-1:0] cur,
    input dir_e                 dir,
    input logic [CNT_W_MAX:0]   modulus
  );
    logic [CNT_W_MAX:0] cur_w;
    logic [CNT_W_MAX:0] res;
    cur_w = {1'b0, cur};
    if (dir == DIR_UP) begin
      res = (cur_w >= modulus - 1'b1) ? '0 : cur_w + 1'b1;
    end else begin
      res = (cur_w == '0 || cur_w >= modulus) ? modulus - 1'b1 : cur_w - 1'b1;
    end
    return res[CNT_W_MAX-1:0];
  endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop: toggles q when t is high, async active-high reset to q=0/qb=1.
module tff_cell (
  input  logic t,
  input  logic clock,
  input  logic reset,
  output logic q,
  output logic qb
);

  logic q_d, q_q;

  always_comb begin
    q_d = t ? ~q_q : q_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) q_q <= 1'b0;
    else       q_q <= q_d;
  end

  assign q  = q_q;
  assign qb = ~q_q;

endmodule

// File: rtl/tff_mod_counter.sv
// Modulo-N up/down counter: computes per-bit toggle enables for a bank of T flops
// so only bits that differ between present and next state toggle.
module tff_mod_counter
  import tff_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_b,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 2 || WIDTH > int'(CNT_W_MAX) || MODULUS < 2 ||
      longint'(MODULUS) > (64'sd1 <<< WIDTH)) begin : g_bad_param
    $error("tff_mod_counter: need 2 <= WIDTH <= 31 and 2 <= MODULUS <= 2**WIDTH");
  end

  localparam logic [CNT_W_MAX:0] MOD_W = (CNT_W_MAX+1)'(MODULUS);
  localparam logic [WIDTH:0]     MOD_X = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0]   TOP_V = WIDTH'(MODULUS - 1);

  dir_e                 dir;
  logic [CNT_W_MAX-1:0] cur_ext;
  logic [WIDTH-1:0]     step_val, load_clamp, next_val, t_vec;
  logic                 wrap_d, wrap_q;

  assign dir     = dir_e'(up_dn);
  assign cur_ext = CNT_W_MAX'(count);

  always_comb begin
    step_val   = WIDTH'(next_count(cur_ext, dir, MOD_W));
    load_clamp = ({1'b0, load_val} >= MOD_X) ? TOP_V : load_val;
    if (load)    next_val = load_clamp;
    else if (en) next_val = step_val;
    else         next_val = count;
    t_vec  = count ^ next_val;
    tc     = en & ~load & (up_dn ? (count == TOP_V) : (count == '0));
    wrap_d = tc;
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    tff_cell u_cell (
      .t     (t_vec[i]),
      .clock (clock),
      .reset (reset),
      .q     (count[i]),
      .qb    (count_b[i])
    );
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) wrap_q <= 1'b0;
    else       wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_mod_counter.sv
// Bench for tff_mod_counter: a mod-10 and a mod-16 instance share stimulus and are
// compared against a modulo-arithmetic reference model.
module tb_tff_mod_counter;

  localparam int W = 4;

  logic         clock = 1'b0;
  logic         reset, en, up_dn, load;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt10, cntb10, cnt16, cntb16;
  logic         tc10, wrap10, tc16, wrap16;

  int checks = 0;
  int errors = 0;
  int m10, m16;
  bit w10, w16;

  always #5 clock = ~clock;

  tff_mod_counter #(.WIDTH(W), .MODULUS(10)) dut10 (
    .clock(clock), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(cnt10), .count_b(cntb10), .tc(tc10), .wrap(wrap10)
  );

  tff_mod_counter #(.WIDTH(W), .MODULUS(16)) dut16 (
    .clock(clock), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .count(cnt16), .count_b(cntb16), .tc(tc16), .wrap(wrap16)
  );

  function automatic int nxt(int c, int m, bit e, bit u, bit l, int lv);
    if (l)  return (lv >= m) ? m - 1 : lv;
    if (!e) return c;
    return u ? (c + 1) % m : (c + m - 1) % m;
  endfunction

  function automatic bit tcm(int c, int m, bit e, bit u, bit l);
    return e && !l && (u ? (c == m - 1) : (c == 0));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state();
    chk("count10",   32'(cnt10),  32'(m10));
    chk("count_b10", 32'(cntb10), 32'((~m10) & 15));
    chk("wrap10",    32'(wrap10), 32'(w10));
    chk("count16",   32'(cnt16),  32'(m16));
    chk("count_b16", 32'(cntb16), 32'((~m16) & 15));
    chk("wrap16",    32'(wrap16), 32'(w16));
  endtask

  // One clock: drive, check tc mid-cycle, step model at the edge, check state after it.
  task automatic cyc(input bit e, input bit u, input bit l, input int lv);
    int n10, n16;
    bit t10, t16;
    en = e; up_dn = u; load = l; load_val = W'(lv);
    #1;
    t10 = tcm(m10, 10, e, u, l);
    t16 = tcm(m16, 16, e, u, l);
    chk("tc10", 32'(tc10), 32'(t10));
    chk("tc16", 32'(tc16), 32'(t16));
    n10 = nxt(m10, 10, e, u, l, lv);
    n16 = nxt(m16, 16, e, u, l, lv);
    @(posedge clock);
    #1;
    m10 = n10; m16 = n16; w10 = t10; w16 = t16;
    check_state();
  endtask

  // Async reset pulse asserted between edges; count must clear before the next edge.
  task automatic mid_reset();
    en = 1'b0; load = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    m10 = 0; m16 = 0; w10 = 1'b0; w16 = 1'b0;
    check_state();
    @(posedge clock);
    #1;
    reset = 1'b0;
    check_state();
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_val = '0;
    m10 = 0; m16 = 0; w10 = 1'b0; w16 = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
    check_state();
    chk("reset_count_b", 32'(cntb10), 32'hF);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, 1'b0, 0);

    // up count across the mod-10 wrap
    for (int i = 0; i < 11; i++) cyc(1'b1, 1'b1, 1'b0, 0);
    chk("up_end", 32'(cnt10), 32'd1);

    // down wrap from 0
    cyc(1'b0, 1'b0, 1'b1, 0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 0);
    chk("down_end", 32'(cnt10), 32'd7);

    // load and clamp; load beats en
    cyc(1'b0, 1'b0, 1'b1, 6);
    cyc(1'b0, 1'b0, 1'b1, 13);
    chk("clamp10", 32'(cnt10), 32'd9);
    chk("noclamp16", 32'(cnt16), 32'd13);
    cyc(1'b1, 1'b1, 1'b1, 6);
    chk("load_wins", 32'(cnt10), 32'd6);

    // direction flip every edge
    cyc(1'b0, 1'b0, 1'b1, 4);
    cyc(1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    cyc(1'b1, 1'b1, 1'b0, 0);
    cyc(1'b1, 1'b0, 1'b0, 0);
    chk("flip_end", 32'(cnt10), 32'd4);

    // async reset at count 7, then mod-16 15 -> 0 wrap
    cyc(1'b0, 1'b0, 1'b1, 7);
    mid_reset();
    chk("async_clear", 32'(cnt10), 32'd0);
    cyc(1'b0, 1'b0, 1'b1, 15);
    cyc(1'b1, 1'b1, 1'b0, 0);
    chk("wrap16_pulse", 32'(wrap16), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 0);
    chk("wrap16_drop", 32'(wrap16), 32'd0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0) mid_reset();
      else cyc(1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom_range(0, 7) == 0),
               int'($urandom_range(0, 15)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
